// File: rtl/gpio_ctrl_pkg.sv
// Shared defaults, direction encoding and the edge-flag set rule for gpio_ctrl.
package gpio_ctrl_pkg;

   localparam int NUM_PINS_DEF   = 8;
   localparam int DEBOUNCE_W_DEF = 4;

   localparam logic DIR_IN  = 1'b0;
   localparam logic DIR_OUT = 1'b1;

   // A flag is raised only for input pins, on an enabled transition of the debounced level.
   function automatic logic edge_set(input logic prev_level, input logic next_level,
                                     input logic rise_en, input logic fall_en,
                                     input logic dir);
      return (dir == DIR_IN) &&
             ((~prev_level & next_level & rise_en) | (prev_level & ~next_level & fall_en));
   endfunction

endpackage

// File: rtl/gpio_ctrl_pin.sv
// One GPIO input lane: 2-flop synchroniser, saturating-free debounce counter and sticky edge flag.
module gpio_ctrl_pin
   import gpio_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_W = DEBOUNCE_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  raw,
   input  logic                  dir,
   input  logic                  rise_en,
   input  logic                  fall_en,
   input  logic [DEBOUNCE_W-1:0] threshold,
   input  logic                  clr,
   output logic                  level,
   output logic                  flag
);

   logic                  s1;
   logic                  s2;
   logic [DEBOUNCE_W-1:0] cnt;
   logic                  level_next;
   logic                  set;

   // The counter only advances while below the threshold, so it cannot wrap.
   always_comb begin
      level_next = level;
      if (s2 != level && cnt >= threshold) begin
         level_next = s2;
      end
      set = edge_set(level, level_next, rise_en, fall_en, dir);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         flag  <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt >= threshold) begin
            level <= s2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         // A new edge outranks a clear arriving on the same cycle.
         flag <= set | (flag & ~clr);
      end
   end

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO controller top: output data/enable registers, per-pin input lanes and the interrupt OR.
module gpio_ctrl
   import gpio_ctrl_pkg::*;
#(
   parameter int NUM_PINS   = NUM_PINS_DEF,
   parameter int DEBOUNCE_W = DEBOUNCE_W_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NUM_PINS-1:0]   gpio_i,
   output logic [NUM_PINS-1:0]   gpio_o,
   output logic [NUM_PINS-1:0]   gpio_oe_o,
   input  logic [NUM_PINS-1:0]   out_data_i,
   input  logic                  out_we_i,
   input  logic [NUM_PINS-1:0]   dir_i,
   input  logic [NUM_PINS-1:0]   rise_en_i,
   input  logic [NUM_PINS-1:0]   fall_en_i,
   input  logic [DEBOUNCE_W-1:0] debounce_i,
   input  logic [NUM_PINS-1:0]   irq_clr_i,
   output logic [NUM_PINS-1:0]   in_data_o,
   output logic [NUM_PINS-1:0]   irq_status_o,
   output logic                  irq_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gpio_o    <= '0;
         gpio_oe_o <= '0;
      end else begin
         if (out_we_i) begin
            gpio_o <= out_data_i;
         end
         gpio_oe_o <= dir_i;
      end
   end

   for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
      gpio_ctrl_pin #(
         .DEBOUNCE_W(DEBOUNCE_W)
      ) u_pin (
         .clk       (clk_i),
         .rst       (rst_i),
         .raw       (gpio_i[p]),
         .dir       (dir_i[p]),
         .rise_en   (rise_en_i[p]),
         .fall_en   (fall_en_i[p]),
         .threshold (debounce_i),
         .clr       (irq_clr_i[p]),
         .level     (in_data_o[p]),
         .flag      (irq_status_o[p])
      );
   end

   assign irq_o = |irq_status_o;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed scenarios then randomized traffic against a behavioural model.
module tb_gpio_ctrl;

   localparam int NP = 8;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NP-1:0] gpio_in;
   logic [NP-1:0] gpio_out;
   logic [NP-1:0] gpio_oe;
   logic [NP-1:0] out_data;
   logic          out_we;
   logic [NP-1:0] dir;
   logic [NP-1:0] rise_en;
   logic [NP-1:0] fall_en;
   logic [DW-1:0] debounce;
   logic [NP-1:0] irq_clr;
   logic [NP-1:0] in_data;
   logic [NP-1:0] irq_status;
   logic          irq;

   int checks = 0;
   int errors = 0;

   // Behavioural model: a level is accepted once it has been the synchronised value for D+1 samples.
   logic [NP-1:0] m_sync1, m_sync2, m_level, m_irq, m_out, m_oe;
   int            m_seen [NP];

   gpio_ctrl #(.NUM_PINS(NP), .DEBOUNCE_W(DW)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .gpio_i       (gpio_in),
      .gpio_o       (gpio_out),
      .gpio_oe_o    (gpio_oe),
      .out_data_i   (out_data),
      .out_we_i     (out_we),
      .dir_i        (dir),
      .rise_en_i    (rise_en),
      .fall_en_i    (fall_en),
      .debounce_i   (debounce),
      .irq_clr_i    (irq_clr),
      .in_data_o    (in_data),
      .irq_status_o (irq_status),
      .irq_o        (irq)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelEdge();
      logic newlv;
      if (rst) begin
         m_sync1 = '0; m_sync2 = '0; m_level = '0; m_irq = '0; m_out = '0; m_oe = '0;
         for (int p = 0; p < NP; p++) m_seen[p] = 0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            newlv = m_level[p];
            if (m_sync2[p] != m_level[p] && m_seen[p] >= int'(debounce)) newlv = m_sync2[p];
            m_irq[p] = (m_irq[p] && !irq_clr[p]) ||
                       (!dir[p] && ((newlv && !m_level[p] && rise_en[p]) ||
                                    (!newlv && m_level[p] && fall_en[p])));
            m_level[p] = newlv;
            if (m_sync1[p] == m_sync2[p]) m_seen[p] = (m_seen[p] < 100) ? m_seen[p] + 1 : 100;
            else m_seen[p] = 0;
         end
         m_sync2 = m_sync1;
         m_sync1 = gpio_in;
         if (out_we) m_out = out_data;
         m_oe = dir;
      end
   endtask

   // One clock edge: advance the model with the driven inputs, then compare every output.
   task automatic applyStimulus(input string tag);
      modelEdge();
      @(posedge clk);
      #1;
      checkOutput({tag, ".gpio_o"}, 32'(gpio_out), 32'(m_out));
      checkOutput({tag, ".gpio_oe_o"}, 32'(gpio_oe), 32'(m_oe));
      checkOutput({tag, ".in_data_o"}, 32'(in_data), 32'(m_level));
      checkOutput({tag, ".irq_status_o"}, 32'(irq_status), 32'(m_irq));
      checkOutput({tag, ".irq_o"}, 32'(irq), 32'(|m_irq));
   endtask

   initial begin
      rst = 1'b1; gpio_in = '0; out_data = '0; out_we = 1'b0; dir = '0;
      rise_en = '0; fall_en = '0; debounce = '0; irq_clr = '0;
      for (int p = 0; p < NP; p++) m_seen[p] = 0;
      m_sync1 = '0; m_sync2 = '0; m_level = '0; m_irq = '0; m_out = '0; m_oe = '0;
      #2;
      applyStimulus("reset");
      applyStimulus("reset");
      checkOutput("reset_irq", 32'(irq), 32'd0);
      checkOutput("reset_gpio_o", 32'(gpio_out), 32'd0);
      rst = 1'b0;
      applyStimulus("idle");

      // Output load and hold
      out_data = 8'hA5; out_we = 1'b1;
      applyStimulus("load");
      checkOutput("load_A5", 32'(gpio_out), 32'hA5);
      out_we = 1'b0; out_data = 8'h3C;
      for (int i = 0; i < 3; i++) applyStimulus("hold");
      checkOutput("hold_A5", 32'(gpio_out), 32'hA5);

      // Debounce latency with D=3: pin0 must appear exactly 6 edges later
      debounce = 4'd3; fall_en = 8'h01;
      for (int i = 0; i < 4; i++) applyStimulus("deb_idle");
      gpio_in[0] = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         applyStimulus("deb_rise");
         checkOutput($sformatf("deb_edge%0d", i), 32'(in_data[0]), (i == 6) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < 3; i++) applyStimulus("deb_settle");
      gpio_in[0] = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus("glitch_low");
      gpio_in[0] = 1'b1;
      for (int i = 0; i < 8; i++) applyStimulus("glitch_after");
      checkOutput("glitch_level", 32'(in_data[0]), 32'd1);
      checkOutput("glitch_noirq", 32'(irq_status), 32'd0);

      // Rising-edge flag on pin2 with D=0, falling edge ignored
      debounce = 4'd0; fall_en = 8'h00; rise_en = 8'h04;
      gpio_in[2] = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus("edge_rise");
      checkOutput("edge_rise_flag", 32'(irq_status), 32'h04);
      gpio_in[2] = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus("edge_fall");
      checkOutput("edge_fall_flag", 32'(irq_status), 32'h04);
      checkOutput("edge_irq", 32'(irq), 32'd1);

      // Clear colliding with a new rise keeps the flag; a lone clear drops it
      gpio_in[2] = 1'b1;
      applyStimulus("coll_a");
      applyStimulus("coll_b");
      irq_clr = 8'h04;
      applyStimulus("coll_edge");
      checkOutput("coll_level", 32'(in_data[2]), 32'd1);
      checkOutput("coll_flag", 32'(irq_status[2]), 32'd1);
      applyStimulus("clear_only");
      checkOutput("clear_flag", 32'(irq_status), 32'd0);
      checkOutput("clear_irq", 32'(irq), 32'd0);
      irq_clr = '0;

      // Output-direction pins track inputs but never flag
      dir = 8'hFF; rise_en = 8'hFF; fall_en = 8'hFF;
      applyStimulus("dir_set");
      checkOutput("dir_oe", 32'(gpio_oe), 32'hFF);
      for (int i = 0; i < 20; i++) begin
         gpio_in = 8'($urandom);
         applyStimulus("dir_toggle");
         checkOutput("dir_noirq", 32'(irq_status), 32'd0);
      end
      gpio_in = 8'h5A;
      for (int i = 0; i < 4; i++) applyStimulus("dir_settle");
      checkOutput("dir_track", 32'(in_data), 32'h5A);

      // Reset mid-count with flags set, then a reported rise D+3 edges after release
      dir = '0; irq_clr = 8'hFF;
      applyStimulus("pre_clr");
      irq_clr = '0; gpio_in = '0;
      for (int i = 0; i < 4; i++) applyStimulus("pre_low");
      gpio_in = 8'hFF;
      for (int i = 0; i < 4; i++) applyStimulus("pre_high");
      checkOutput("pre_flags", 32'(irq_status), 32'hFF);
      gpio_in = '0;
      for (int i = 0; i < 4; i++) applyStimulus("pre_low2");
      debounce = 4'd7; gpio_in = 8'hFF; dir = 8'hFF;
      for (int i = 0; i < 5; i++) applyStimulus("midcount");
      rst = 1'b1;
      applyStimulus("rst_mid");
      checkOutput("rst_all", {gpio_out, gpio_oe, in_data, irq_status}, 32'd0);
      checkOutput("rst_irq", 32'(irq), 32'd0);
      rst = 1'b0; dir = '0;
      for (int i = 1; i <= 10; i++) begin
         applyStimulus("post_rst");
         checkOutput($sformatf("post_rst_edge%0d", i), 32'(irq_status), (i == 10) ? 32'hFF : 32'd0);
      end

      // Randomized traffic in blocks of fixed-or-shifting thresholds
      for (int blk = 0; blk < 12; blk++) begin
         debounce = 4'($urandom_range(0, 4));
         dir = 8'($urandom); rise_en = 8'($urandom); fall_en = 8'($urandom);
         for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) gpio_in = gpio_in ^ 8'($urandom);
            out_we = ($urandom_range(0, 4) == 0);
            out_data = 8'($urandom);
            irq_clr = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) == 0) debounce = 4'($urandom_range(0, 6));
            applyStimulus("random");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
